// File: rtl/ysyx_24100006_xbar.sv
// ysyx_24100006_xbar
// Single-master, three-slave AXI-lite style crossbar. One transaction is in
// flight at a time. The master request is latched, decoded to a one-hot slave
// select (bit0 SRAM, bit1 CLINT, bit2 UART) and replayed towards that slave;
// the response channel is passed back combinationally. Addresses outside all
// regions are answered locally with a 2'b11 decode-error response.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   m_ar*/m_r*                 master read address / read data channels
//   m_aw*/m_w*/m_b*/m_bytes    master write address / data / response channels
//   s_araddr/s_awaddr/s_wdata  latched address and data, broadcast to slaves
//   s_bytes                    latched write byte mask, broadcast to slaves
//   s_*valid/s_*ready          per-slave handshakes, one bit per slave
//   s_rdata/s_rresp/s_bresp    per-slave response buses, slave i in slice i
module ysyx_24100006_xbar #(
  parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE  = 32'h0800_0000,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0008,
  parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_araddr,
  input  logic [31:0] m_awaddr,
  input  logic [31:0] m_wdata,
  input  logic [7:0]  m_bytes,
  input  logic        m_arvalid,
  input  logic        m_rready,
  input  logic        m_awvalid,
  input  logic        m_wvalid,
  input  logic        m_bready,
  output logic        m_arready,
  output logic        m_rvalid,
  output logic        m_awready,
  output logic        m_wready,
  output logic        m_bvalid,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic [1:0]  m_bresp,
  output logic [31:0] s_araddr,
  output logic [31:0] s_awaddr,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_bytes,
  output logic [2:0]  s_arvalid,
  output logic [2:0]  s_rready,
  output logic [2:0]  s_awvalid,
  output logic [2:0]  s_wvalid,
  output logic [2:0]  s_bready,
  input  logic [2:0]  s_arready,
  input  logic [2:0]  s_rvalid,
  input  logic [2:0]  s_awready,
  input  logic [2:0]  s_wready,
  input  logic [2:0]  s_bvalid,
  input  logic [95:0] s_rdata,
  input  logic [5:0]  s_rresp,
  input  logic [5:0]  s_bresp
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WRESP,
    RERR,
    WERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  sel;
  logic        issued;
  logic        aw_done;
  logic        w_done;
  logic [2:0]  ar_sel;
  logic [2:0]  aw_sel;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        write_done;
  logic        slave_rvalid;
  logic        slave_bvalid;
  logic [31:0] slave_rdata;
  logic [1:0]  slave_rresp;
  logic [1:0]  slave_bresp;

  // Region hit test done in 33 bits so that BASE+SIZE cannot wrap to zero.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic [2:0] decode(input logic [31:0] addr);
    return {in_region(addr, UART_BASE, UART_SIZE),
            in_region(addr, CLINT_BASE, CLINT_SIZE),
            in_region(addr, SRAM_BASE, SRAM_SIZE)};
  endfunction

  assign ar_sel = decode(m_araddr);
  assign aw_sel = decode(m_awaddr);

  assign ar_hs = |(s_arvalid & s_arready);
  assign aw_hs = |(s_awvalid & s_awready);
  assign w_hs  = |(s_wvalid & s_wready);

  // The address and data handshakes may finish on different cycles, so each
  // is remembered separately; the write phase ends once both have happened.
  assign write_done = issued && (aw_done || aw_hs) && (w_done || w_hs);

  assign slave_rvalid = |(s_rvalid & sel);
  assign slave_bvalid = |(s_bvalid & sel);

  // Response mux from the selected slave; sel is one-hot so OR-ing is safe.
  always_comb begin
    slave_rdata = '0;
    slave_rresp = '0;
    slave_bresp = '0;
    for (int i = 0; i < 3; i++) begin
      if (sel[i]) begin
        slave_rdata = slave_rdata | s_rdata[32*i +: 32];
        slave_rresp = slave_rresp | s_rresp[2*i +: 2];
        slave_bresp = slave_bresp | s_bresp[2*i +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a pending read always takes priority over a write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m_arvalid) begin
          state_next = (|ar_sel) ? RADDR : RERR;
        end else if (m_awvalid && m_wvalid) begin
          state_next = (|aw_sel) ? WADDR : WERR;
        end
      end
      RADDR: begin
        if (ar_hs) state_next = RDATA;
      end
      RDATA: begin
        if (slave_rvalid && m_rready) state_next = IDLE;
      end
      WADDR: begin
        if (write_done) state_next = WRESP;
      end
      WRESP: begin
        if (slave_bvalid && m_bready) state_next = IDLE;
      end
      RERR: begin
        if (m_rready) state_next = IDLE;
      end
      WERR: begin
        if (m_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response-side outputs are a combinational pass-through of the selected
  // slave, or a locally generated decode error; zero in every other state.
  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_bvalid = 1'b0;
    m_bresp  = '0;
    s_rready = '0;
    s_bready = '0;
    case (state)
      RDATA: begin
        m_rvalid = slave_rvalid;
        m_rdata  = slave_rdata;
        m_rresp  = slave_rresp;
        s_rready = sel & {3{m_rready}};
      end
      WRESP: begin
        m_bvalid = slave_bvalid;
        m_bresp  = slave_bresp;
        s_bready = sel & {3{m_bready}};
      end
      RERR: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
      end
      WERR: begin
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
      end
      default: begin
      end
    endcase
  end

  // Request latching and slave-side valids. The master ready pulses last one
  // cycle; slave valids rise the cycle after entering RADDR/WADDR and each
  // drops as soon as its own handshake completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_arready <= 1'b0;
      m_awready <= 1'b0;
      m_wready  <= 1'b0;
      s_araddr  <= '0;
      s_awaddr  <= '0;
      s_wdata   <= '0;
      s_bytes   <= '0;
      s_arvalid <= '0;
      s_awvalid <= '0;
      s_wvalid  <= '0;
      sel       <= '0;
      issued    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      m_arready <= 1'b0;
      m_awready <= 1'b0;
      m_wready  <= 1'b0;
      case (state)
        IDLE: begin
          if (m_arvalid) begin
            s_araddr  <= m_araddr;
            sel       <= ar_sel;
            m_arready <= 1'b1;
          end else if (m_awvalid && m_wvalid) begin
            s_awaddr  <= m_awaddr;
            s_wdata   <= m_wdata;
            s_bytes   <= m_bytes;
            sel       <= aw_sel;
            m_awready <= 1'b1;
            m_wready  <= 1'b1;
          end
        end
        RADDR: begin
          if (s_arvalid == 3'b000) begin
            s_arvalid <= sel;
          end else if (ar_hs) begin
            s_arvalid <= '0;
          end
        end
        WADDR: begin
          if (!issued) begin
            s_awvalid <= sel;
            s_wvalid  <= sel;
            issued    <= 1'b1;
          end else begin
            if (aw_hs) begin
              s_awvalid <= '0;
              aw_done   <= 1'b1;
            end
            if (w_hs) begin
              s_wvalid <= '0;
              w_done   <= 1'b1;
            end
            if (write_done) begin
              issued  <= 1'b0;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_xbar.sv
// tb_ysyx_24100006_xbar
// Directed self-checking bench for the crossbar. The bench plays both the
// master and all three slaves, stepping cycle by cycle with hand-computed
// expected values; inputs change 1 ns after the rising edge and outputs are
// sampled there too, well away from the active edge.
module tb_ysyx_24100006_xbar;

  logic        clk;
  logic        reset;
  logic [31:0] m_araddr;
  logic [31:0] m_awaddr;
  logic [31:0] m_wdata;
  logic [7:0]  m_bytes;
  logic        m_arvalid;
  logic        m_rready;
  logic        m_awvalid;
  logic        m_wvalid;
  logic        m_bready;
  logic        m_arready;
  logic        m_rvalid;
  logic        m_awready;
  logic        m_wready;
  logic        m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [1:0]  m_bresp;
  logic [31:0] s_araddr;
  logic [31:0] s_awaddr;
  logic [31:0] s_wdata;
  logic [7:0]  s_bytes;
  logic [2:0]  s_arvalid;
  logic [2:0]  s_rready;
  logic [2:0]  s_awvalid;
  logic [2:0]  s_wvalid;
  logic [2:0]  s_bready;
  logic [2:0]  s_arready;
  logic [2:0]  s_rvalid;
  logic [2:0]  s_awready;
  logic [2:0]  s_wready;
  logic [2:0]  s_bvalid;
  logic [95:0] s_rdata;
  logic [5:0]  s_rresp;
  logic [5:0]  s_bresp;

  int checks   = 0;
  int failures = 0;

  // Decode table: address and the slave it must reach (0 = decode error).
  localparam int NTBL = 12;
  localparam logic [31:0] TBL_ADDR [NTBL] = '{
    32'h8000_0000, 32'h87ff_fffc, 32'h8800_0000, 32'h7fff_fffc,
    32'ha000_0048, 32'ha000_004f, 32'ha000_0050, 32'ha000_03f8,
    32'ha000_03ff, 32'ha000_0400, 32'h0000_0000, 32'hffff_fffc
  };
  localparam logic [2:0] TBL_SEL [NTBL] = '{
    3'b001, 3'b001, 3'b000, 3'b000,
    3'b010, 3'b010, 3'b000, 3'b100,
    3'b100, 3'b000, 3'b000, 3'b000
  };

  ysyx_24100006_xbar dut (
    .clk       (clk),
    .reset     (reset),
    .m_araddr  (m_araddr),
    .m_awaddr  (m_awaddr),
    .m_wdata   (m_wdata),
    .m_bytes   (m_bytes),
    .m_arvalid (m_arvalid),
    .m_rready  (m_rready),
    .m_awvalid (m_awvalid),
    .m_wvalid  (m_wvalid),
    .m_bready  (m_bready),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_awready (m_awready),
    .m_wready  (m_wready),
    .m_bvalid  (m_bvalid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_bresp   (m_bresp),
    .s_araddr  (s_araddr),
    .s_awaddr  (s_awaddr),
    .s_wdata   (s_wdata),
    .s_bytes   (s_bytes),
    .s_arvalid (s_arvalid),
    .s_rready  (s_rready),
    .s_awvalid (s_awvalid),
    .s_wvalid  (s_wvalid),
    .s_bready  (s_bready),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_awready (s_awready),
    .s_wready  (s_wready),
    .s_bvalid  (s_bvalid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_bresp   (s_bresp)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic arv, input logic [31:0] ara,
                               input logic awv, input logic wv,
                               input logic [31:0] awa, input logic [31:0] wd,
                               input logic [7:0] by);
    m_arvalid = arv;
    m_araddr  = ara;
    m_awvalid = awv;
    m_wvalid  = wv;
    m_awaddr  = awa;
    m_wdata   = wd;
    m_bytes   = by;
    #1;
  endtask

  // Complete read through the crossbar; expSel==0 means a decode error.
  task automatic readTxn(input logic [31:0] addr, input logic [2:0] expSel,
                         input logic [31:0] data, input logic [1:0] resp);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    checkOutput("rd_arready", 32'(m_arready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    if (expSel == 3'b000) begin
      checkOutput("rerr_rvalid", 32'(m_rvalid), 32'd1);
      checkOutput("rerr_rresp", 32'(m_rresp), 32'd3);
      checkOutput("rerr_rdata", m_rdata, 32'h0);
      checkOutput("rerr_s_arvalid", 32'(s_arvalid), 32'd0);
      m_rready = 1'b1;
      step();
      checkOutput("rerr_done", 32'(m_rvalid), 32'd0);
      m_rready = 1'b0;
    end else begin
      step();
      checkOutput("rd_s_arvalid", 32'(s_arvalid), 32'(expSel));
      checkOutput("rd_s_araddr", s_araddr, addr);
      s_arready = expSel;
      step();
      checkOutput("rd_s_arvalid_drop", 32'(s_arvalid), 32'd0);
      s_arready = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (expSel[i]) begin
          s_rdata[32*i +: 32] = data;
          s_rresp[2*i +: 2]   = resp;
        end else begin
          s_rdata[32*i +: 32] = ~data;
          s_rresp[2*i +: 2]   = 2'b10;
        end
      end
      s_rvalid = expSel;
      m_rready = 1'b1;
      #1;
      checkOutput("rd_rvalid", 32'(m_rvalid), 32'd1);
      checkOutput("rd_rdata", m_rdata, data);
      checkOutput("rd_rresp", 32'(m_rresp), 32'(resp));
      checkOutput("rd_s_rready", 32'(s_rready), 32'(expSel));
      step();
      checkOutput("rd_done", 32'(m_rvalid), 32'd0);
      m_rready = 1'b0;
      s_rvalid = 3'b000;
      s_rdata  = '0;
      s_rresp  = '0;
    end
  endtask

  initial begin
    reset     = 1'b0;
    m_rready  = 1'b0;
    m_bready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_bresp   = '0;

    // Requests held during reset must not be accepted.
    applyStimulus(1'b1, 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0020, 32'h1, 8'hff);
    #22;
    checkOutput("rst_arready", 32'(m_arready), 32'd0);
    checkOutput("rst_awready", 32'(m_awready), 32'd0);
    checkOutput("rst_s_araddr", s_araddr, 32'h0);
    checkOutput("rst_s_awaddr", s_awaddr, 32'h0);
    checkOutput("rst_s_arvalid", 32'(s_arvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(m_rvalid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    reset = 1'b1;

    // SRAM read with the master stalling rready for five cycles.
    applyStimulus(1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    checkOutput("sram_arready_early", 32'(m_arready), 32'd0);
    step();
    checkOutput("sram_arready", 32'(m_arready), 32'd1);
    checkOutput("sram_s_araddr", s_araddr, 32'h8000_0010);
    checkOutput("sram_s_arvalid_lat", 32'(s_arvalid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    checkOutput("sram_s_arvalid", 32'(s_arvalid), 32'b001);
    checkOutput("sram_arready_pulse", 32'(m_arready), 32'd0);
    s_arready = 3'b001;
    step();
    checkOutput("sram_s_arvalid_drop", 32'(s_arvalid), 32'd0);
    s_arready = 3'b000;
    s_rdata   = {32'h1111_1111, 32'h2222_2222, 32'hdead_beef};
    s_rresp   = 6'b10_10_00;
    s_rvalid  = 3'b001;
    #1;
    checkOutput("sram_rvalid", 32'(m_rvalid), 32'd1);
    checkOutput("sram_rdata", m_rdata, 32'hdead_beef);
    checkOutput("sram_rresp", 32'(m_rresp), 32'd0);
    checkOutput("sram_s_rready_low", 32'(s_rready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stall_rvalid", 32'(m_rvalid), 32'd1);
      checkOutput("stall_rdata", m_rdata, 32'hdead_beef);
    end
    m_rready = 1'b1;
    #1;
    checkOutput("sram_s_rready", 32'(s_rready), 32'b001);
    step();
    checkOutput("sram_done", 32'(m_rvalid), 32'd0);
    m_rready = 1'b0;
    s_rvalid = 3'b000;
    s_rdata  = '0;
    s_rresp  = '0;

    // UART write; address handshake completes a cycle before data.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'ha000_03f8, 32'h41, 8'h01);
    step();
    checkOutput("uw_awready", 32'(m_awready), 32'd1);
    checkOutput("uw_wready", 32'(m_wready), 32'd1);
    checkOutput("uw_s_awaddr", s_awaddr, 32'ha000_03f8);
    checkOutput("uw_s_wdata", s_wdata, 32'h41);
    checkOutput("uw_s_bytes", 32'(s_bytes), 32'h01);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    checkOutput("uw_s_awvalid", 32'(s_awvalid), 32'b100);
    checkOutput("uw_s_wvalid", 32'(s_wvalid), 32'b100);
    checkOutput("uw_awready_pulse", 32'(m_awready), 32'd0);
    s_awready = 3'b100;
    step();
    checkOutput("uw_s_awvalid_drop", 32'(s_awvalid), 32'd0);
    checkOutput("uw_s_wvalid_hold", 32'(s_wvalid), 32'b100);
    s_awready = 3'b000;
    s_wready  = 3'b100;
    step();
    checkOutput("uw_s_wvalid_drop", 32'(s_wvalid), 32'd0);
    checkOutput("uw_bvalid_wait", 32'(m_bvalid), 32'd0);
    s_wready = 3'b000;
    s_bvalid = 3'b100;
    s_bresp  = 6'b00_00_11;
    m_bready = 1'b1;
    #1;
    checkOutput("uw_bvalid", 32'(m_bvalid), 32'd1);
    checkOutput("uw_bresp", 32'(m_bresp), 32'd0);
    checkOutput("uw_s_bready", 32'(s_bready), 32'b100);
    step();
    checkOutput("uw_done", 32'(m_bvalid), 32'd0);
    m_bready = 1'b0;
    s_bvalid = 3'b000;
    s_bresp  = '0;

    // Decode boundaries for all regions, including UART SLVERR forwarding.
    for (int i = 0; i < NTBL; i++) begin
      readTxn(TBL_ADDR[i], TBL_SEL[i], TBL_ADDR[i] ^ 32'h5a5a_0f0f,
              TBL_SEL[i][2] ? 2'b01 : 2'b00);
    end

    // Write to an unmapped address gets a decode error without touching slaves.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'ha000_0400, 32'h77, 8'h0f);
    step();
    checkOutput("werr_awready", 32'(m_awready), 32'd1);
    checkOutput("werr_bvalid", 32'(m_bvalid), 32'd1);
    checkOutput("werr_bresp", 32'(m_bresp), 32'd3);
    checkOutput("werr_s_awvalid", 32'(s_awvalid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    checkOutput("werr_hold", 32'(m_bvalid), 32'd1);
    checkOutput("werr_s_wvalid", 32'(s_wvalid), 32'd0);
    m_bready = 1'b1;
    step();
    checkOutput("werr_done", 32'(m_bvalid), 32'd0);
    m_bready = 1'b0;

    // Simultaneous read and write: UART read first, then SRAM write.
    applyStimulus(1'b1, 32'ha000_03f8, 1'b1, 1'b1, 32'h8000_0100, 32'hcafe_f00d, 8'h0f);
    step();
    checkOutput("both_arready", 32'(m_arready), 32'd1);
    checkOutput("both_awready_no", 32'(m_awready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0100, 32'hcafe_f00d, 8'h0f);
    step();
    checkOutput("both_s_arvalid", 32'(s_arvalid), 32'b100);
    checkOutput("both_s_awvalid_no", 32'(s_awvalid), 32'd0);
    s_arready = 3'b100;
    step();
    s_arready = 3'b000;
    s_rdata   = {32'h0000_0041, 64'h0};
    s_rresp   = 6'b01_00_00;
    s_rvalid  = 3'b100;
    m_rready  = 1'b1;
    #1;
    checkOutput("both_rvalid", 32'(m_rvalid), 32'd1);
    checkOutput("both_rdata", m_rdata, 32'h41);
    checkOutput("both_rresp_slverr", 32'(m_rresp), 32'd1);
    step();
    checkOutput("both_rd_done", 32'(m_rvalid), 32'd0);
    checkOutput("both_awready_wait", 32'(m_awready), 32'd0);
    m_rready = 1'b0;
    s_rvalid = 3'b000;
    s_rdata  = '0;
    s_rresp  = '0;
    step();
    checkOutput("both_awready", 32'(m_awready), 32'd1);
    checkOutput("both_wready", 32'(m_wready), 32'd1);
    checkOutput("both_s_awaddr", s_awaddr, 32'h8000_0100);
    checkOutput("both_s_wdata", s_wdata, 32'hcafe_f00d);
    checkOutput("both_s_bytes", 32'(s_bytes), 32'h0f);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    checkOutput("both_s_awvalid", 32'(s_awvalid), 32'b001);
    checkOutput("both_s_wvalid", 32'(s_wvalid), 32'b001);
    s_awready = 3'b001;
    s_wready  = 3'b001;
    step();
    checkOutput("both_s_awvalid_drop", 32'(s_awvalid), 32'd0);
    checkOutput("both_s_wvalid_drop", 32'(s_wvalid), 32'd0);
    s_awready = 3'b000;
    s_wready  = 3'b000;
    s_bvalid  = 3'b001;
    m_bready  = 1'b1;
    #1;
    checkOutput("both_bvalid", 32'(m_bvalid), 32'd1);
    checkOutput("both_bresp", 32'(m_bresp), 32'd0);
    checkOutput("both_s_bready", 32'(s_bready), 32'b001);
    step();
    checkOutput("both_wr_done", 32'(m_bvalid), 32'd0);
    m_bready = 1'b0;
    s_bvalid = 3'b000;

    // Reset pulsed mid-write clears outputs at once and drops the transaction.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'ha000_0048, 32'h5, 8'h0f);
    step();
    checkOutput("mid_awready", 32'(m_awready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    step();
    checkOutput("mid_s_awvalid", 32'(s_awvalid), 32'b010);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_s_awvalid", 32'(s_awvalid), 32'd0);
    checkOutput("mid_rst_s_wvalid", 32'(s_wvalid), 32'd0);
    checkOutput("mid_rst_s_awaddr", s_awaddr, 32'h0);
    checkOutput("mid_rst_s_wdata", s_wdata, 32'h0);
    checkOutput("mid_rst_s_bytes", 32'(s_bytes), 32'h0);
    step();
    reset = 1'b1;
    m_bready = 1'b1;
    step();
    checkOutput("mid_no_bvalid", 32'(m_bvalid), 32'd0);
    checkOutput("mid_no_s_awvalid", 32'(s_awvalid), 32'd0);
    m_bready = 1'b0;
    readTxn(32'h8000_0020, 3'b001, 32'h0bad_cafe, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_xbar.md
YSYX_24100006_XBAR -- requirements
Module: ysyx_24100006_xbar

Interface
REQ-001 SHALL have parameter SRAM_BASE, default 32'h8000_0000, meaning the SRAM region base.
REQ-002 SHALL have parameter SRAM_SIZE, default 32'h0800_0000, meaning the SRAM region size in bytes.
REQ-003 SHALL have parameter CLINT_BASE, default 32'ha000_0048, meaning the CLINT region base.
REQ-004 SHALL have parameter CLINT_SIZE, default 32'h8, meaning the CLINT region size in bytes.
REQ-005 SHALL have parameter UART_BASE, default 32'ha000_03f8, meaning the UART region base.
REQ-006 SHALL have parameter UART_SIZE, default 32'h8, meaning the UART region size in bytes.
REQ-007 SHALL have the following ports, in this order:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_araddr, m_awaddr, m_wdata  in  32 each  master read address, write address, write data.
- m_bytes  in  8  master write byte mask.
- m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready  in  1 each  master valids and readys.
- m_arready, m_rvalid, m_awready, m_wready, m_bvalid  out  1 each  master handshake outputs.
- m_rdata  out  32  read data.
- m_rresp, m_bresp  out  2 each  read and write responses.
- s_araddr, s_awaddr, s_wdata  out  32 each  latched address/data, broadcast to all slaves.
- s_bytes  out  8  latched byte mask, broadcast.
- s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready  out  3 each  per-slave handshakes; bit0 SRAM, bit1 CLINT, bit2 UART.
- s_arready, s_rvalid, s_awready, s_wready, s_bvalid  in  3 each  per-slave handshake returns.
- s_rdata  in  96  slave i read data in bits [32i+31:32i].
- s_rresp, s_bresp  in  6 each  slave i response in bits [2i+1:2i].

Function
REQ-008 SHALL decode region hit as BASE <= addr < BASE+SIZE, using unsigned 33-bit compare so BASE+SIZE never wraps.
- Any address outside all three regions is a decode error.
REQ-009 SHALL serve one transaction at a time, with states IDLE, RADDR, RDATA, WADDR, WRESP, RERR, WERR.
REQ-010 In IDLE with m_arvalid=1, SHALL latch m_araddr, latch the one-hot select, pulse m_arready for 1 cycle, and go to RADDR, or to RERR on decode error.
- Reads win over writes when both are pending.
REQ-011 In IDLE with m_arvalid=0 and m_awvalid=1 and m_wvalid=1, SHALL latch awaddr/wdata/bytes, pulse m_awready and m_wready for 1 cycle, and go to WADDR, or to WERR on decode error.
- m_awvalid alone SHALL NOT be accepted.
REQ-012 In RADDR, SHALL drive s_arvalid[sel]=1 until s_arready[sel]=1 is seen, then go to RDATA; all other bits SHALL be 0.
REQ-013 In RDATA, SHALL pass through combinationally:
- m_rvalid = s_rvalid[sel], m_rdata/m_rresp from slave sel, s_rready[sel] = m_rready.
- Go to IDLE on the cycle where m_rvalid=1 and m_rready=1.
REQ-014 In WADDR, SHALL drive s_awvalid[sel]=1 and s_wvalid[sel]=1 together, holding both until s_awready[sel]=1 and s_wready[sel]=1 have each been seen (tracked separately), then go to WRESP.
REQ-015 In WRESP, SHALL pass through m_bvalid/m_bresp from slave sel, drive s_bready[sel] = m_bready, and go to IDLE on the b handshake.
REQ-016 In RERR, SHALL drive m_rvalid=1, m_rdata=0, m_rresp=2'b11 until m_rready=1, then go to IDLE; no slave signal SHALL be asserted.
REQ-017 In WERR, SHALL drive m_bvalid=1, m_bresp=2'b11 until m_bready=1, then go to IDLE.
REQ-018 Minimum read latency SHALL be: m_arready 1 cycle after m_arvalid; slave s_arvalid 1 cycle later; response added by the slave passes with zero cycles.
REQ-019 Slave-returned SLVERR (2'b01, e.g. a UART read) SHALL be forwarded unchanged.
REQ-020 Per-slave output bits SHALL be 0 outside the states in which they are driven.

Reset
REQ-021 reset=0 SHALL asynchronously force:
- state to IDLE;
- all m_* and s_* outputs to 0, including latched address, data and mask registers.
REQ-022 Deassertion of reset SHALL take effect at the next rising clk edge.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no response issued.

Verification
REQ-024 Read 32'h8000_0010, SRAM returns 32'hdeadbeef/00 -> m_rdata=32'hdeadbeef, m_rresp=00; s_arvalid only ever 3'b001.
REQ-025 Write 32'ha000_03f8, wdata=32'h41, bytes=8'h01 -> s_awvalid = s_wvalid = 3'b100, s_wdata=32'h41, m_bresp=00 after UART bvalid.
REQ-026 Read 32'h0000_0000 -> m_rvalid with m_rresp=11 and m_rdata=0; s_arvalid stays 0; write to 32'ha000_0400 -> m_bresp=11.
REQ-027 m_arvalid and m_awvalid+m_wvalid asserted in the same cycle -> read completes first, then the write; UART read with rresp=01 -> m_rresp=01.
REQ-028 m_rready held low 5 cycles during RDATA -> m_rvalid and m_rdata stable; reset=0 pulsed in WADDR -> all outputs 0 immediately, next transaction proceeds normally.
